// File: rtl/trig_cordic.sv
// trig_cordic: iterative CORDIC sine/cosine of an unsigned 4.8 angle.
//   The angle is reduced modulo 2*pi by repeated subtraction, folded into the
//   first quadrant, then rotated through ITERATIONS micro-steps on a signed
//   4.12 datapath. The results are rounded back to signed 4.8.
// Ports:
//   Clk      - clock, rising edge
//   Reset    - asynchronous active-low reset
//   start    - request strobe, sampled only while idle
//   theta    - angle in radians, unsigned 4.8
//   busy     - high while a computation is in progress
//   done     - one-cycle pulse when sin_out/cos_out are updated
//   sin_out  - sine, signed 4.8 (1.0 = 0x100)
//   cos_out  - cosine, signed 4.8
module trig_cordic #(
    parameter int ITERATIONS = 12
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [11:0] theta,
    output logic        busy,
    output logic        done,
    output logic [11:0] sin_out,
    output logic [11:0] cos_out
);

    localparam logic [11:0]        TWO_PI  = 12'h648;
    localparam logic [11:0]        HALF_PI = 12'h192;
    localparam logic [11:0]        PI      = 12'h324;
    localparam logic [11:0]        PI_3_2  = 12'h4B6;
    localparam logic signed [15:0] GAIN    = 16'sh09B7;   // 1/K in 4.12
    localparam logic [3:0]         LAST    = 4'(ITERATIONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_FOLD, S_ITER} state_t;

    state_t             r_state;
    logic [11:0]        r_ang;
    logic [1:0]         r_quad;
    logic [3:0]         r_iter;
    logic signed [15:0] r_x;
    logic signed [15:0] r_y;
    logic signed [15:0] r_z;

    logic [1:0]         w_quad;
    logic [11:0]        w_res;
    logic signed [15:0] w_xs;
    logic signed [15:0] w_ys;
    logic signed [15:0] w_x_next;
    logic signed [15:0] w_y_next;
    logic signed [15:0] w_z_next;

    // round(atan(2^-i) * 4096)
    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'sd3217;
            4'd1:    return 16'sd1899;
            4'd2:    return 16'sd1003;
            4'd3:    return 16'sd509;
            4'd4:    return 16'sd256;
            4'd5:    return 16'sd128;
            4'd6:    return 16'sd64;
            4'd7:    return 16'sd32;
            4'd8:    return 16'sd16;
            4'd9:    return 16'sd8;
            4'd10:   return 16'sd4;
            4'd11:   return 16'sd2;
            4'd12:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    // 4.12 -> 4.8 with round-half-up
    function automatic logic [11:0] rnd48(input logic signed [15:0] v);
        return 12'((v + 16'sd8) >>> 4);
    endfunction

    // Quadrant fold of the already-reduced angle
    always_comb begin
        w_quad = 2'd3;
        w_res  = r_ang - PI_3_2;
        if (r_ang < HALF_PI) begin
            w_quad = 2'd0;
            w_res  = r_ang;
        end else if (r_ang < PI) begin
            w_quad = 2'd1;
            w_res  = r_ang - HALF_PI;
        end else if (r_ang < PI_3_2) begin
            w_quad = 2'd2;
            w_res  = r_ang - PI;
        end
    end

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        w_xs = r_x >>> r_iter;
        w_ys = r_y >>> r_iter;
        if (!r_z[15]) begin
            w_x_next = r_x - w_ys;
            w_y_next = r_y + w_xs;
            w_z_next = r_z - atan_lut(r_iter);
        end else begin
            w_x_next = r_x + w_ys;
            w_y_next = r_y - w_xs;
            w_z_next = r_z + atan_lut(r_iter);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_ang   <= '0;
            r_quad  <= '0;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sin_out <= '0;
            cos_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ang   <= theta;
                        busy    <= 1'b1;
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (r_ang >= TWO_PI) r_ang <= r_ang - TWO_PI;
                    else                 r_state <= S_FOLD;
                end
                S_FOLD: begin
                    r_quad  <= w_quad;
                    r_x     <= GAIN;
                    r_y     <= '0;
                    r_z     <= {w_res, 4'b0000};
                    r_iter  <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_x    <= w_x_next;
                    r_y    <= w_y_next;
                    r_z    <= w_z_next;
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == LAST) begin
                        // Outputs come straight from the final step's values,
                        // so they update on the same edge as the last rotation.
                        case (r_quad)
                            2'd0: begin
                                sin_out <= rnd48(w_y_next);
                                cos_out <= rnd48(w_x_next);
                            end
                            2'd1: begin
                                sin_out <= rnd48(w_x_next);
                                cos_out <= rnd48(-w_y_next);
                            end
                            2'd2: begin
                                sin_out <= rnd48(-w_y_next);
                                cos_out <= rnd48(-w_x_next);
                            end
                            default: begin
                                sin_out <= rnd48(-w_x_next);
                                cos_out <= rnd48(w_y_next);
                            end
                        endcase
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
